uart_cmd_rx: RTL and testbench
==============================

Name: uart_cmd_rx

Overview:
- UART receiver that turns ASCII key commands from a host serial link into one-cycle game command pulses.
- Its outputs have the same form as the debounced button outputs, so the game core ORs them with btnL/btnR/btnD/btnS.
- Also provides pause and reset requests, and a raw byte strobe for debug.
- Sits beside the debouncers in the top level, clocked by the system clk.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); minimum 4.
- SYNC_STAGES, 2, number of rx synchronizer flops; minimum 2.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line; idles high.
- cmd_left  output  1  one-cycle pulse on 'a'/'A'.
- cmd_right  output  1  one-cycle pulse on 'd'/'D'.
- cmd_down  output  1  one-cycle pulse on 's'/'S'.
- cmd_rotate  output  1  one-cycle pulse on 'w'/'W'.
- cmd_pause  output  1  one-cycle pulse on 'p'/'P' (toggle request).
- cmd_reset  output  1  one-cycle pulse on 'r'/'R'.
- data_out  output  8  last correctly framed byte; holds until the next good byte.
- data_valid  output  1  one-cycle pulse when data_out updates.
- frame_err  output  1  one-cycle pulse on a bad stop bit (or bad parity, see option).

Behaviour:
- Reset:
  - All outputs 0, data_out = 8'h00, FSM in IDLE.
  - Synchronizer flops and bit counter preset to 1; baud counter 0.
  - A reset mid-frame discards the partial byte; no pulse is generated.
- Input sampling: rx passes through SYNC_STAGES flops. All decisions use the synchronized value rs.
- Frame format: 8N1, LSB first.
- FSM:
  - IDLE: on rs==0, load baud counter and go to START.
  - START: after CLKS_PER_BIT/2 cycles (integer division), sample rs.
    - If rs==0: go to DATA.
    - Otherwise: treat as a glitch, return to IDLE, no output.
  - DATA: every CLKS_PER_BIT cycles, shift rs into bit (index 0..7). After bit 7, go to STOP (or PARITY when the option is on).
  - STOP: after CLKS_PER_BIT cycles, sample rs.
    - rs==1: good frame; go to IDLE.
    - rs==0: framing error; go to BREAK.
  - BREAK: wait for rs==1, then go to IDLE. No new start bit is detected while in BREAK.
- Output timing:
  - All outputs are registered.
  - Pulses are asserted exactly 1 clk after the stop-bit sample cycle and last exactly 1 cycle.
- Decode on a good frame:
  - Case-insensitive match on data.
  - At most one cmd_* asserted at a time.
  - data_valid always asserted for a good frame, whether or not the byte matches a command.
  - Unrecognized bytes: data_valid only.
- Framing error: frame_err only; no cmd_*, no data_valid, data_out unchanged.
- Back-to-back frames: a start bit arriving right after the stop-bit sample is accepted. IDLE re-arms in the cycle after STOP.
- Counters:
  - Baud counter is clog2(CLKS_PER_BIT)+1 bits and counts down to 0.
  - Bit index is 3 bits and does not wrap within a frame.

Optional Feature:
- Macro: UART_CMD_PARITY_EN.
- When defined:
  - Frame is 8E1; a PARITY state between DATA and STOP samples the parity bit.
  - The frame is bad if (^data ^ parity) != 0.
  - A bad-parity frame with a good stop bit gives a frame_err pulse at the usual output cycle, with no cmd_*/data_valid, then returns to IDLE (not BREAK).
- When undefined: 8N1 only, the PARITY state and its logic are absent, and all timing is as above.

Decomposition:
- Package uart_cmd_pkg holds:
  - state encoding (IDLE, START, DATA, PARITY, STOP, BREAK);
  - ASCII constants for the command letters, upper and lower case;
  - CMD_* one-hot indices for the command vector.
- Sub-module uart_rx_core: synchronizer, baud counter and FSM.
  - Outputs byte[7:0], byte_ok and byte_err pulses.
- Top level uart_cmd_rx: registered ASCII decode of byte into cmd_* and data_out/data_valid.
  - Output pulse alignment to the stop-bit sample is a property of the whole block, so the core and decode stages together must meet the 1-clk figure.

Test Plan (CLKS_PER_BIT=16):
- Send 0x61 ('a') as 8N1 → cmd_left high for 1 cycle, 1 clk after the stop sample; data_out=0x61; data_valid pulse; no other cmd_*.
- Send 'W' then 'd' back-to-back with no idle gap → cmd_rotate pulse, then cmd_right pulse 160 clks later; data_out ends at 0x64.
- Send 0x7A ('z') → data_valid pulse only; all cmd_* stay 0; data_out=0x7A.
- Drive an rx low glitch of 4 clks → no outputs; FSM back in IDLE; a following 'r' yields cmd_reset.
- Send 's' with the stop bit forced low, holding rx low for 40 clks before releasing → frame_err pulse only; data_out unchanged; a next 'p' yields cmd_pause.
- Assert rst for 1 cycle during bit 3 of 'a' → no pulses from that frame; a next 'd' yields cmd_right. With UART_CMD_PARITY_EN: 'a' with wrong parity gives frame_err only.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command receiver.
// Optional 8E1 framing is enabled by defining UART_CMD_PARITY_EN.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_CMD_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_e;

  localparam logic [7:0] ASCII_A_LC = 8'h61;
  localparam logic [7:0] ASCII_A_UC = 8'h41;
  localparam logic [7:0] ASCII_D_LC = 8'h64;
  localparam logic [7:0] ASCII_D_UC = 8'h44;
  localparam logic [7:0] ASCII_S_LC = 8'h73;
  localparam logic [7:0] ASCII_S_UC = 8'h53;
  localparam logic [7:0] ASCII_W_LC = 8'h77;
  localparam logic [7:0] ASCII_W_UC = 8'h57;
  localparam logic [7:0] ASCII_P_LC = 8'h70;
  localparam logic [7:0] ASCII_P_UC = 8'h50;
  localparam logic [7:0] ASCII_R_LC = 8'h72;
  localparam logic [7:0] ASCII_R_UC = 8'h52;

  localparam int unsigned CMD_W      = 6;
  localparam int unsigned CMD_LEFT   = 0;
  localparam int unsigned CMD_RIGHT  = 1;
  localparam int unsigned CMD_DOWN   = 2;
  localparam int unsigned CMD_ROTATE = 3;
  localparam int unsigned CMD_PAUSE  = 4;
  localparam int unsigned CMD_RESET  = 5;

  // Case-insensitive key map; unknown bytes give an all-zero vector.
  function automatic logic [CMD_W-1:0] decode_cmd(input logic [7:0] b);
    logic [CMD_W-1:0] v;
    v = '0;
    case (b)
      ASCII_A_LC, ASCII_A_UC: v[CMD_LEFT]   = 1'b1;
      ASCII_D_LC, ASCII_D_UC: v[CMD_RIGHT]  = 1'b1;
      ASCII_S_LC, ASCII_S_UC: v[CMD_DOWN]   = 1'b1;
      ASCII_W_LC, ASCII_W_UC: v[CMD_ROTATE] = 1'b1;
      ASCII_P_LC, ASCII_P_UC: v[CMD_PAUSE]  = 1'b1;
      ASCII_R_LC, ASCII_R_UC: v[CMD_RESET]  = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART receive core: rx synchronizer, baud counter and framing FSM.
// 8N1 by default; UART_CMD_PARITY_EN adds an even-parity bit (8E1).
module uart_rx_core
  import uart_cmd_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_ok_c_o,
  output logic       byte_err_c_o
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rs;
  rx_state_e              state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [2:0]             bit_idx_q;
  logic [7:0]             shift_q;
  logic                   tick;
`ifdef UART_CMD_PARITY_EN
  logic                   par_err_q;
`endif

  // Line idles high, so the synchronizer presets to 1 to avoid a false start.
  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
  end

  assign rs   = sync_q[SYNC_STAGES-1];
  assign tick = (cnt_q == '0);

  // Framing FSM; each sample point is where the baud counter reaches zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '1;
      shift_q   <= '0;
`ifdef UART_CMD_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!rs) begin
            cnt_q   <= HALF_LOAD;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (!tick) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else if (!rs) begin
            cnt_q     <= BIT_LOAD;
            bit_idx_q <= '0;
`ifdef UART_CMD_PARITY_EN
            par_err_q <= 1'b0;
`endif
            state_q   <= ST_DATA;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_DATA: begin
          if (!tick) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            shift_q <= {rs, shift_q[7:1]};
            cnt_q   <= BIT_LOAD;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_CMD_PARITY_EN
              state_q <= ST_PARITY;
`else
              state_q <= ST_STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end
`ifdef UART_CMD_PARITY_EN
        ST_PARITY: begin
          if (!tick) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            par_err_q <= (^shift_q) ^ rs;
            cnt_q     <= BIT_LOAD;
            state_q   <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (!tick) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else if (rs) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_BREAK;
          end
        end
        ST_BREAK: begin
          if (rs) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Result strobes are combinational so the top can register them in one stage.
  always_comb begin
    byte_ok_c_o  = 1'b0;
    byte_err_c_o = 1'b0;
    if (state_q == ST_STOP && tick) begin
      if (!rs) begin
        byte_err_c_o = 1'b1;
`ifdef UART_CMD_PARITY_EN
      end else if (par_err_q) begin
        byte_err_c_o = 1'b1;
`endif
      end else begin
        byte_ok_c_o = 1'b1;
      end
    end
  end

  assign byte_o = shift_q;

endmodule

// File: rtl/uart_cmd_rx.sv
// UART key-command receiver: registers decoded command pulses, the last good
// byte and error strobes. Define UART_CMD_PARITY_EN for 8E1 framing.
module uart_cmd_rx
  import uart_cmd_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       cmd_left,
  output logic       cmd_right,
  output logic       cmd_down,
  output logic       cmd_rotate,
  output logic       cmd_pause,
  output logic       cmd_reset,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err
);

  logic [7:0]       rx_byte;
  logic             byte_ok_c;
  logic             byte_err_c;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  uart_rx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .SYNC_STAGES  (SYNC_STAGES)
  ) u_core (
    .clk_i        (clk),
    .rst_i        (rst),
    .rx_i         (rx),
    .byte_o       (rx_byte),
    .byte_ok_c_o  (byte_ok_c),
    .byte_err_c_o (byte_err_c)
  );

  // Decode only good frames; a bad frame leaves data_out untouched.
  always_comb begin
    cmd_d   = '0;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = byte_err_c;
    if (byte_ok_c) begin
      cmd_d   = decode_cmd(rx_byte);
      data_d  = rx_byte;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q   <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign cmd_left   = cmd_q[CMD_LEFT];
  assign cmd_right  = cmd_q[CMD_RIGHT];
  assign cmd_down   = cmd_q[CMD_DOWN];
  assign cmd_rotate = cmd_q[CMD_ROTATE];
  assign cmd_pause  = cmd_q[CMD_PAUSE];
  assign cmd_reset  = cmd_q[CMD_RESET];
  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Scoreboard bench for uart_cmd_rx with CLKS_PER_BIT=16; honours UART_CMD_PARITY_EN.
`timescale 1ns/1ps
module tb_uart_cmd_rx;

  localparam int unsigned CPB  = 16;
  localparam int unsigned SYNC = 2;
`ifdef UART_CMD_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif
  // rx edge -> sync -> IDLE -> half bit -> remaining bits to the stop sample, plus output register
  localparam int unsigned LAT = SYNC + 1 + CPB / 2 + (FRAME_BITS - 1) * CPB;

  // Expected cmd vector: {reset, pause, rotate, down, right, left}
  localparam logic [5:0] E_NONE  = 6'b000000;
  localparam logic [5:0] E_LEFT  = 6'b000001;
  localparam logic [5:0] E_RIGHT = 6'b000010;
  localparam logic [5:0] E_DOWN  = 6'b000100;
  localparam logic [5:0] E_ROT   = 6'b001000;
  localparam logic [5:0] E_PAUSE = 6'b010000;
  localparam logic [5:0] E_RESET = 6'b100000;

  typedef struct {
    logic [5:0]  cmd;
    logic        dv;
    logic        fe;
    logic [7:0]  data;
    int unsigned cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       cmd_left, cmd_right, cmd_down, cmd_rotate, cmd_pause, cmd_reset;
  logic [7:0] data_out;
  logic       data_valid, frame_err;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  logic [7:0]  last_data;
  logic        prev_any = 1'b0;
`ifdef UART_CMD_PARITY_EN
  logic        par_flip = 1'b0;
`endif

  uart_cmd_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .cmd_left   (cmd_left),
    .cmd_right  (cmd_right),
    .cmd_down   (cmd_down),
    .cmd_rotate (cmd_rotate),
    .cmd_pause  (cmd_pause),
    .cmd_reset  (cmd_reset),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_bit(input logic v, input int unsigned n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Caller is aligned to posedge+1; the expectation is queued before the start bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int unsigned stop_clks,
                            input exp_t e);
    e.cyc = cyc + LAT;
    exp_q.push_back(e);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
`ifdef UART_CMD_PARITY_EN
    drive_bit((^b) ^ par_flip, CPB);
`endif
    drive_bit(stop_v, stop_clks);
  endtask

  task automatic send_good(input logic [7:0] b, input logic [5:0] exp_cmd);
    exp_t e;
    e.cmd = exp_cmd; e.dv = 1'b1; e.fe = 1'b0; e.data = b; e.cyc = 0;
    last_data = b;
    send_frame(b, 1'b1, CPB, e);
  endtask

  task automatic send_bad_stop(input logic [7:0] b, input int unsigned hold);
    exp_t e;
    e.cmd = E_NONE; e.dv = 1'b0; e.fe = 1'b1; e.data = last_data; e.cyc = 0;
    send_frame(b, 1'b0, hold, e);
  endtask

  // Monitor: every active output cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [5:0] act;
    logic       any;
    exp_t       e;
    if (rst !== 1'b1) begin
      act = {cmd_reset, cmd_pause, cmd_rotate, cmd_down, cmd_right, cmd_left};
      any = (|act) | data_valid | frame_err;
      if (any) begin
        chk("pulse_width_prev_quiet", 32'(prev_any), 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {24'd0, data_valid, frame_err, act}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("cmd_vector", 32'(act), 32'(e.cmd));
          chk("data_valid", 32'(data_valid), 32'(e.dv));
          chk("frame_err", 32'(frame_err), 32'(e.fe));
          chk("data_out", 32'(data_out), 32'(e.data));
          chk("pulse_cycle", cyc, e.cyc);
        end
      end
      prev_any = any;
    end else begin
      prev_any = 1'b0;
    end
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: got running expected finished (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rx = 1'b1;
    rst = 1'b1;
    last_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cmds", {26'd0, cmd_reset, cmd_pause, cmd_rotate, cmd_down, cmd_right, cmd_left}, 32'd0);
    chk("reset_data_out", 32'(data_out), 32'h00);
    chk("reset_data_valid", 32'(data_valid), 32'd0);
    chk("reset_frame_err", 32'(frame_err), 32'd0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    send_good(8'h61, E_LEFT);
    drive_bit(1'b1, 2 * CPB);

    // back-to-back, no idle gap
    send_good(8'h57, E_ROT);
    send_good(8'h64, E_RIGHT);
    drive_bit(1'b1, 2 * CPB);

    send_good(8'h7A, E_NONE);
    drive_bit(1'b1, 2 * CPB);

    // short low glitch must be rejected at the start-bit midpoint
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 3 * CPB);
    send_good(8'h72, E_RESET);
    drive_bit(1'b1, 2 * CPB);

    // stop bit held low into a break
    send_bad_stop(8'h73, 40);
    drive_bit(1'b1, 2 * CPB);
    send_good(8'h70, E_PAUSE);
    drive_bit(1'b1, 2 * CPB);

    // reset in the middle of bit 3 of 'a'; the sender abandons the frame
    drive_bit(1'b0, CPB);
    drive_bit(1'b1, CPB);
    drive_bit(1'b0, CPB);
    drive_bit(1'b0, CPB);
    drive_bit(1'b0, CPB / 2);
    rst = 1'b1;
    rx  = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_data = 8'h00;
    chk("midframe_reset_data_out", 32'(data_out), 32'h00);
    drive_bit(1'b1, 3 * CPB);
    send_good(8'h64, E_RIGHT);
    drive_bit(1'b1, 2 * CPB);

    // uppercase variants
    send_good(8'h41, E_LEFT);
    drive_bit(1'b1, CPB);
    send_good(8'h53, E_DOWN);
    drive_bit(1'b1, CPB);
    send_good(8'h50, E_PAUSE);
    drive_bit(1'b1, 2 * CPB);

`ifdef UART_CMD_PARITY_EN
    begin
      exp_t e;
      e.cmd = E_NONE; e.dv = 1'b0; e.fe = 1'b1; e.data = last_data; e.cyc = 0;
      par_flip = 1'b1;
      send_frame(8'h61, 1'b1, CPB, e);
      par_flip = 1'b0;
    end
    send_good(8'h77, E_ROT);
    drive_bit(1'b1, 2 * CPB);
`endif

    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
